// File: rtl/lcd_pkg.sv
// lcd_pkg: shared encodings, geometry and window indexing for the LCD host driver
package lcd_pkg;
    localparam int IMG_W = 6;
    localparam int WIN = 3;
    localparam int IMG_PIX = IMG_W * IMG_W;
    localparam logic [1:0] ORIGIN_RST = 2'd2;
    localparam logic [2:0] CMD_REFRESH = 3'd0;
    localparam logic [2:0] CMD_LOAD = 3'd1;
    localparam logic [2:0] CMD_RIGHT = 3'd2;
    localparam logic [2:0] CMD_LEFT = 3'd3;
    localparam logic [2:0] CMD_UP = 3'd4;
    localparam logic [2:0] CMD_DOWN = 3'd5;
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_STREAM, S_COLLECT, S_RESP} state_t;
    // image index of window slot (raster order) for origin (ox, oy)
    function automatic logic [5:0] win_idx(input logic [1:0] ox, input logic [1:0] oy, input logic [3:0] slot);
        logic [1:0] r;
        logic [1:0] c;
        r = (slot >= 4'd6) ? 2'd2 : (slot >= 4'd3) ? 2'd1 : 2'd0;
        c = 2'(slot - 4'(3 * r));
        return 6'(({4'd0, oy} + {4'd0, r}) * 6'(IMG_W)) + {4'd0, ox} + {4'd0, c};
    endfunction
endpackage

// File: rtl/lcd_img_buf.sv
// lcd_img_buf: 36x8 image store, one write port and two asynchronous read ports
module lcd_img_buf
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [5:0] rd_addr_a,
    output logic [7:0] rd_data_a,
    input  logic [5:0] rd_addr_b,
    output logic [7:0] rd_data_b
);
    logic [7:0] mem [IMG_PIX];
    always_ff @(posedge clk)
        if (we) mem[wr_addr] <= wr_data;
    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];
endmodule

// File: rtl/lcd_host_driver.sv
// lcd_host_driver: command initiator for the 6x6 LCD controller; LCD_CHECK_EN adds a shadow-origin window checker
module lcd_host_driver
    import lcd_pkg::*;
#(
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_cmd,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  pix_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [71:0] res_window,
    output logic        res_err,
    output logic        res_mismatch,
    output logic [2:0]  lcd_cmd,
    output logic        lcd_cmd_valid,
    output logic [7:0]  lcd_datain,
    input  logic        lcd_busy,
    input  logic [7:0]  lcd_dataout,
    input  logic        lcd_output_valid
);
    state_t state;
    logic [2:0] cmd;
    logic [5:0] wr_ptr;
    logic [5:0] rd_ptr;
    logic [3:0] slot;
    logic [5:0] cyc;
    logic [7:0] rd_data;
    logic we;
    logic done;
    logic timed_out;
    logic pix_bad;
    assign we = state == S_FILL && pix_valid && pix_ready;
    assign done = state == S_COLLECT && lcd_output_valid && slot == 4'(WIN * WIN - 1);
    assign timed_out = cyc == 6'(TIMEOUT - 1);
`ifdef LCD_CHECK_EN
    logic [1:0] ox;
    logic [1:0] oy;
    logic loaded;
    logic [7:0] chk_data;
    assign pix_bad = loaded && lcd_dataout != chk_data;
    lcd_img_buf u_buf (
        .clk(clk), .we(we), .wr_addr(wr_ptr), .wr_data(pix_data),
        .rd_addr_a(rd_ptr), .rd_data_a(rd_data),
        .rd_addr_b(win_idx(ox, oy, slot)), .rd_data_b(chk_data)
    );
`else
    assign pix_bad = 1'b0;
    lcd_img_buf u_buf (
        .clk(clk), .we(we), .wr_addr(wr_ptr), .wr_data(pix_data),
        .rd_addr_a(rd_ptr), .rd_data_a(rd_data),
        .rd_addr_b(6'd0), .rd_data_b()
    );
`endif
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= S_IDLE;
            cmd <= CMD_REFRESH;
            wr_ptr <= '0;
            rd_ptr <= '0;
            slot <= '0;
            cyc <= '0;
            req_ready <= 1'b0;
            pix_ready <= 1'b0;
            res_valid <= 1'b0;
            res_window <= '0;
            res_err <= 1'b0;
            res_mismatch <= 1'b0;
            lcd_cmd <= CMD_REFRESH;
            lcd_cmd_valid <= 1'b0;
            lcd_datain <= '0;
`ifdef LCD_CHECK_EN
            ox <= ORIGIN_RST;
            oy <= ORIGIN_RST;
            loaded <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE:
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        cmd <= req_cmd;
                        res_window <= '0;
                        res_err <= req_cmd > CMD_DOWN;
                        res_mismatch <= 1'b0;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        slot <= '0;
                        pix_ready <= req_cmd == CMD_LOAD;
                        res_valid <= req_cmd > CMD_DOWN;
                        state <= req_cmd == CMD_LOAD ? S_FILL : req_cmd > CMD_DOWN ? S_RESP : S_ISSUE;
`ifdef LCD_CHECK_EN
                        // shadow origin tracks the controller's saturating window moves
                        ox <= req_cmd == CMD_LOAD ? ORIGIN_RST :
                              req_cmd == CMD_RIGHT && ox != 2'd3 ? ox + 2'd1 :
                              req_cmd == CMD_LEFT && ox != 2'd0 ? ox - 2'd1 : ox;
                        oy <= req_cmd == CMD_LOAD ? ORIGIN_RST :
                              req_cmd == CMD_DOWN && oy != 2'd3 ? oy + 2'd1 :
                              req_cmd == CMD_UP && oy != 2'd0 ? oy - 2'd1 : oy;
                        loaded <= loaded || req_cmd == CMD_LOAD;
`endif
                    end else begin
                        req_ready <= 1'b1;
                    end
                S_FILL:
                    if (we) begin
                        wr_ptr <= wr_ptr + 6'd1;
                        if (wr_ptr == 6'(IMG_PIX - 1)) begin
                            pix_ready <= 1'b0;
                            state <= S_ISSUE;
                        end
                    end
                S_ISSUE:
                    if (lcd_cmd_valid) begin
                        lcd_cmd_valid <= 1'b0;
                        cyc <= 6'd1;
                        if (cmd == CMD_LOAD) begin
                            lcd_datain <= rd_data;
                            rd_ptr <= rd_ptr + 6'd1;
                            state <= S_STREAM;
                        end else begin
                            state <= S_COLLECT;
                        end
                    end else if (!lcd_busy) begin
                        lcd_cmd_valid <= 1'b1;
                        lcd_cmd <= cmd;
                    end
                S_STREAM, S_COLLECT: begin
                    cyc <= cyc + 6'd1;
                    if (state == S_STREAM) begin
                        lcd_datain <= rd_ptr == 6'(IMG_PIX) ? 8'd0 : rd_data;
                        rd_ptr <= rd_ptr + 6'd1;
                        if (rd_ptr == 6'(IMG_PIX)) state <= S_COLLECT;
                    end else if (lcd_output_valid) begin
                        res_window[{slot, 3'b000} +: 8] <= lcd_dataout;
                        slot <= slot + 4'd1;
                        if (pix_bad) res_mismatch <= 1'b1;
                    end
                    if (done || timed_out) begin
                        state <= S_RESP;
                        res_valid <= 1'b1;
                        res_err <= !done;
                        lcd_datain <= '0;
                    end
                end
                S_RESP:
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state <= S_IDLE;
                    end
                default: state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_lcd_host_driver.sv
// tb_lcd_host_driver: directed bench acting as both upstream host and LCD controller
module tb_lcd_host_driver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0;
    logic [2:0] req_cmd = 3'd0;
    logic pix_valid = 1'b0;
    logic [7:0] pix_data = 8'd0;
    logic res_ready = 1'b0;
    logic lcd_busy = 1'b0;
    logic [7:0] lcd_dataout = 8'd0;
    logic lcd_output_valid = 1'b0;
    logic req_ready, pix_ready, res_valid, res_err, res_mismatch, lcd_cmd_valid;
    logic [71:0] res_window;
    logic [2:0] lcd_cmd;
    logic [7:0] lcd_datain;
    int total = 0;
    int bad = 0;
    localparam logic [71:0] W_LOAD = 72'h1c1b1a161514100f0e;
    localparam logic [71:0] W_RIGHT = 72'h1d1c1b17161511100f;
    localparam logic [71:0] W_UL = 72'h0e0d0c080706020100;
`ifdef LCD_CHECK_EN
    localparam logic MM_EXP = 1'b1;
`else
    localparam logic MM_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    lcd_host_driver dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_window(res_window),
        .res_err(res_err), .res_mismatch(res_mismatch),
        .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid), .lcd_datain(lcd_datain),
        .lcd_busy(lcd_busy), .lcd_dataout(lcd_dataout), .lcd_output_valid(lcd_output_valid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // window of the 0..35 ramp image at origin (ox, oy)
    function automatic logic [71:0] win_of(input int ox, input int oy);
        logic [71:0] w;
        w = '0;
        for (int s = 0; s < 9; s++) w[s*8 +: 8] = 8'((oy + s / 3) * 6 + ox + s % 3);
        return w;
    endfunction

    task automatic send(input logic [2:0] c);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_cmd = c;
        while (!req_ready && n < 50) begin
            tick;
            n++;
        end
        check("req_ready_wait", 72'(req_ready), 72'(1));
        tick;
        req_valid = 1'b0;
    endtask

    task automatic fill;
        int k;
        int n;
        logic acc;
        k = 0;
        n = 0;
        while (k < 36 && n < 200) begin
            pix_valid = (n % 3) != 2;
            pix_data = 8'(k);
            acc = pix_valid && pix_ready;
            tick;
            if (acc) k++;
            n++;
        end
        pix_valid = 1'b0;
        check("fill_count", 72'(k), 72'(36));
    endtask

    task automatic wait_strobe;
        int n;
        n = 0;
        while (!lcd_cmd_valid && n < 40) begin
            tick;
            n++;
        end
        check("cmd_valid_seen", 72'(lcd_cmd_valid), 72'(1));
    endtask

    task automatic serve(input logic [2:0] c, input bit load, input logic [71:0] w, input bit respond);
        wait_strobe;
        check("lcd_cmd", 72'(lcd_cmd), 72'(c));
        tick;
        check("strobe_one_cycle", 72'(lcd_cmd_valid), 72'(0));
        if (load)
            for (int k = 0; k < 36; k++) begin
                check("datain", 72'(lcd_datain), 72'(k));
                tick;
            end
        if (respond) begin
            for (int s = 0; s < 9; s++) begin
                lcd_output_valid = 1'b1;
                lcd_dataout = w[s*8 +: 8];
                tick;
            end
            lcd_output_valid = 1'b0;
        end
    endtask

    task automatic resp(input logic [71:0] w, input logic e, input logic m);
        int n;
        n = 0;
        while (!res_valid && n < 80) begin
            tick;
            n++;
        end
        check("res_valid", 72'(res_valid), 72'(1));
        check("res_window", res_window, w);
        check("res_err", 72'(res_err), 72'(e));
        check("res_mismatch", 72'(res_mismatch), 72'(m));
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        check("res_valid_drop", 72'(res_valid), 72'(0));
        check("req_ready_back", 72'(req_ready), 72'(1));
    endtask

    task automatic do_cmd(input logic [2:0] c, input logic [71:0] w);
        send(c);
        serve(c, 1'b0, w, 1'b1);
        resp(w, 1'b0, 1'b0);
    endtask

    task automatic do_load;
        send(3'd1);
        fill;
        serve(3'd1, 1'b1, W_LOAD, 1'b1);
        resp(W_LOAD, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick;
        check("rst_req_ready", 72'(req_ready), 72'(0));
        check("rst_pix_ready", 72'(pix_ready), 72'(0));
        check("rst_res_valid", 72'(res_valid), 72'(0));
        check("rst_cmd_valid", 72'(lcd_cmd_valid), 72'(0));
        check("rst_lcd_cmd", 72'(lcd_cmd), 72'(0));
        check("rst_datain", 72'(lcd_datain), 72'(0));
        check("rst_window", res_window, 72'(0));
        reset = 1'b0;
        tick;
        check("idle_req_ready", 72'(req_ready), 72'(1));
        do_load;
        send(3'd2);
        serve(3'd2, 1'b0, W_RIGHT, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 72'(res_valid), 72'(1));
            check("hold_window", res_window, W_RIGHT);
            check("hold_req_ready", 72'(req_ready), 72'(0));
            tick;
        end
        resp(W_RIGHT, 1'b0, 1'b0);
        do_cmd(3'd2, W_RIGHT);
        do_cmd(3'd4, win_of(3, 1));
        do_cmd(3'd4, win_of(3, 0));
        do_cmd(3'd4, win_of(3, 0));
        do_cmd(3'd3, win_of(2, 0));
        do_cmd(3'd3, win_of(1, 0));
        send(3'd3);
        serve(3'd3, 1'b0, win_of(0, 0), 1'b1);
        resp(W_UL, 1'b0, 1'b0);
        send(3'd7);
        check("badcmd_no_strobe", 72'(lcd_cmd_valid), 72'(0));
        resp(72'(0), 1'b1, 1'b0);
        send(3'd6);
        resp(72'(0), 1'b1, 1'b0);
        lcd_busy = 1'b1;
        send(3'd0);
        for (int i = 0; i < 4; i++) begin
            check("busy_hold", 72'(lcd_cmd_valid), 72'(0));
            tick;
        end
        lcd_busy = 1'b0;
        serve(3'd0, 1'b0, 72'(0), 1'b0);
        repeat (61) tick;
        check("timeout_early", 72'(res_valid), 72'(0));
        tick;
        check("timeout_at_limit", 72'(res_valid), 72'(1));
        resp(72'(0), 1'b1, 1'b0);
        lcd_output_valid = 1'b1;
        lcd_dataout = 8'haa;
        repeat (2) tick;
        lcd_output_valid = 1'b0;
        send(3'd0);
        serve(3'd0, 1'b0, W_UL ^ 72'hff, 1'b1);
        resp(W_UL ^ 72'hff, 1'b0, MM_EXP);
        send(3'd1);
        fill;
        wait_strobe;
        repeat (10) tick;
        check("mid_stream_datain", 72'(lcd_datain), 72'(9));
        reset = 1'b1;
        #1;
        check("abort_cmd_valid", 72'(lcd_cmd_valid), 72'(0));
        check("abort_datain", 72'(lcd_datain), 72'(0));
        check("abort_res_valid", 72'(res_valid), 72'(0));
        tick;
        reset = 1'b0;
        tick;
        check("abort_req_ready", 72'(req_ready), 72'(1));
        do_load;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
